// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared types and constants for the alarm clock front-panel sequencer:
//   - edit FSM state, snooze scheduler state and load target enums
//   - BCD digit maxima for the 24-hour HH:MM fields
//   - digit_step / h0_limit helpers for wrapping increment/decrement
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT_H1 = 3'd1,
    ST_EDIT_H0 = 3'd2,
    ST_EDIT_M1 = 3'd3,
    ST_EDIT_M0 = 3'd4,
    ST_LOAD    = 3'd5
  } edit_state_e;

  typedef enum logic [1:0] {
    SN_QUIET    = 2'd0,
    SN_SNOOZING = 2'd1,
    SN_RINGING  = 2'd2
  } snooze_state_e;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_e;

  localparam logic [1:0] H1_MAX    = 2'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_20 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  // Wrapping step of one BCD digit inside 0..max. An out-of-range value
  // (possible only after H1 changes underneath H0) snaps back into range.
  function automatic logic [3:0] digit_step(input logic [3:0] cur,
                                            input logic [3:0] max,
                                            input logic       up);
    logic [3:0] res;
    if (up) begin
      res = (cur >= max) ? 4'd0 : cur + 4'd1;
    end else begin
      res = ((cur == 4'd0) || (cur > max)) ? max : cur - 4'd1;
    end
    return res;
  endfunction

  // Upper limit of the H0 digit: 20..23 only when H1 is 2.
  function automatic logic [3:0] h0_limit(input logic [1:0] h1);
    return (h1 == H1_MAX) ? H0_MAX_20 : H0_MAX;
  endfunction

endpackage

// File: rtl/snooze_timer.sv
// -----------------------------------------------------------------------------
// snooze_timer
// Snooze scheduler for the alarm core: QUIET / SNOOZING / RINGING, a snooze
// down-counter and the STOP_al hold window.
// Ports:
//   clk, reset       : 10 Hz clock, asynchronous active-high reset
//   btn_snooze_i     : snooze button pulse
//   btn_stop_i       : stop button pulse
//   alarm_in_i       : Alarm output of the clock core
//   stop_al_o        : STOP_al strobe to the core, held LD_HOLD cycles
//   snooze_ring_o    : high once the snooze delay has elapsed
// -----------------------------------------------------------------------------
module snooze_timer
  import alarm_pkg::*;
#(
  parameter int LD_HOLD      = 12,
  parameter int SNOOZE_TICKS = 3000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_snooze_i,
  input  logic btn_stop_i,
  input  logic alarm_in_i,
  output logic stop_al_o,
  output logic snooze_ring_o
);

  localparam int HOLD_W = $clog2(LD_HOLD + 1);
  localparam int CNT_W  = $clog2(SNOOZE_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LD_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(SNOOZE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  snooze_state_e     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HOLD_W-1:0] hold_q;
  logic              stop_al_q;
  logic              snooze_ring_q;

  logic ring_s;
  logic stop_ev_s;
  logic snooze_ev_s;

  assign ring_s      = alarm_in_i | snooze_ring_q;
  // Stop is honoured whenever something rings or a snooze is pending.
  assign stop_ev_s   = btn_stop_i & (ring_s | (state_q == SN_SNOOZING));
  // Stop beats snooze when both arrive together.
  assign snooze_ev_s = btn_snooze_i & ~btn_stop_i & ring_s;

  // Snooze scheduler state and down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SN_QUIET;
      cnt_q         <= '0;
      snooze_ring_q <= 1'b0;
    end else if (stop_ev_s) begin
      state_q       <= SN_QUIET;
      cnt_q         <= '0;
      snooze_ring_q <= 1'b0;
    end else if (snooze_ev_s) begin
      state_q       <= SN_SNOOZING;
      cnt_q         <= CNT_INIT;
      snooze_ring_q <= 1'b0;
    end else begin
      case (state_q)
        SN_SNOOZING: begin
          // Reaching 0 happens exactly SNOOZE_TICKS edges after the load.
          if (cnt_q > CNT_ONE) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            cnt_q         <= '0;
            state_q       <= SN_RINGING;
            snooze_ring_q <= 1'b1;
          end
        end
        SN_QUIET, SN_RINGING: begin
          state_q <= state_q;
        end
        default: begin
          state_q       <= SN_QUIET;
          cnt_q         <= '0;
          snooze_ring_q <= 1'b0;
        end
      endcase
    end
  end

  // STOP_al hold window; any new stop/snooze event restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      stop_al_q <= 1'b0;
    end else if (stop_ev_s | snooze_ev_s) begin
      hold_q    <= HOLD_INIT;
      stop_al_q <= 1'b1;
    end else if (hold_q > HOLD_ONE) begin
      hold_q    <= hold_q - HOLD_ONE;
      stop_al_q <= stop_al_q;
    end else begin
      hold_q    <= '0;
      stop_al_q <= 1'b0;
    end
  end

  assign stop_al_o     = stop_al_q;
  assign snooze_ring_o = snooze_ring_q;

endmodule

// File: rtl/alarm_set_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_set_ctrl
// Front-panel sequencer for the 24-hour alarm clock core. Stages HH:MM digits
// from button pulses, then strobes LD_time / LD_alarm for LD_HOLD cycles so the
// core's 1-s domain captures them. Hosts the snooze scheduler.
// Ports:
//   clk, reset                 : 10 Hz clock, asynchronous active-high reset
//   btn_time, btn_alarm        : enter edit (IDLE) / increment, decrement (EDIT)
//   btn_ok, btn_cancel         : advance digit / abandon edit
//   btn_snooze, btn_stop       : snooze scheduler controls
//   alarm_in                   : Alarm output of the core
//   H_in1, H_in0, M_in1, M_in0 : staged BCD digits
//   LD_time, LD_alarm, STOP_al : load / stop strobes to the core
//   edit_pos                   : digit under edit (0=H1 .. 3=M0)
//   busy                       : edit or load in progress
//   ring                       : buzzer drive, alarm_in | snooze ring
// -----------------------------------------------------------------------------
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int LD_HOLD     = 12,
  parameter int TICKS_PER_S = 10,
  parameter int SNOOZE_S    = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_time,
  input  logic       btn_alarm,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  input  logic       alarm_in,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic [1:0] edit_pos,
  output logic       busy,
  output logic       ring
);

  localparam int HOLD_W = $clog2(LD_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LD_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  edit_state_e       state_q;
  target_e           target_q;
  logic [1:0]        h1_q;
  logic [3:0]        h0_q;
  logic [3:0]        m1_q;
  logic [3:0]        m0_q;
  logic [HOLD_W-1:0] hold_q;
  logic              ld_time_q;
  logic              ld_alarm_q;
  logic [1:0]        edit_pos_q;
  logic              busy_q;

  logic       adj_s;
  logic [3:0] h1_step_s;
  logic [3:0] h0_step_s;
  logic [3:0] m1_step_s;
  logic [3:0] m0_step_s;
  logic [3:0] h0_clamp_s;
  logic       snooze_ring_s;

  // While editing, btn_time steps up and btn_alarm steps down; up wins a tie.
  assign adj_s      = btn_time | btn_alarm;
  assign h1_step_s  = digit_step({2'b00, h1_q}, {2'b00, H1_MAX}, btn_time);
  assign h0_step_s  = digit_step(h0_q, h0_limit(h1_q), btn_time);
  assign m1_step_s  = digit_step(m1_q, M1_MAX, btn_time);
  assign m0_step_s  = digit_step(m0_q, M0_MAX, btn_time);
  // Leaving H1 as 2 must not leave an hour of 24..29 behind.
  assign h0_clamp_s = ((h1_q == H1_MAX) && (h0_q > H0_MAX_20)) ? H0_MAX_20 : h0_q;

  // Edit FSM with staging registers, load hold counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      target_q   <= TGT_TIME;
      h1_q       <= 2'd0;
      h0_q       <= 4'd0;
      m1_q       <= 4'd0;
      m0_q       <= 4'd0;
      hold_q     <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      edit_pos_q <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_time) begin
            state_q    <= ST_EDIT_H1;
            target_q   <= TGT_TIME;
            edit_pos_q <= 2'd0;
            busy_q     <= 1'b1;
          end else if (btn_alarm) begin
            state_q    <= ST_EDIT_H1;
            target_q   <= TGT_ALARM;
            edit_pos_q <= 2'd0;
            busy_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EDIT_H1: begin
          if (btn_cancel) begin
            state_q    <= ST_IDLE;
            edit_pos_q <= 2'd0;
            busy_q     <= 1'b0;
          end else if (btn_ok) begin
            state_q    <= ST_EDIT_H0;
            edit_pos_q <= 2'd1;
            h0_q       <= h0_clamp_s;
          end else if (adj_s) begin
            h1_q <= h1_step_s[1:0];
          end else begin
            h1_q <= h1_q;
          end
        end
        ST_EDIT_H0: begin
          if (btn_cancel) begin
            state_q    <= ST_IDLE;
            edit_pos_q <= 2'd0;
            busy_q     <= 1'b0;
          end else if (btn_ok) begin
            state_q    <= ST_EDIT_M1;
            edit_pos_q <= 2'd2;
          end else if (adj_s) begin
            h0_q <= h0_step_s;
          end else begin
            h0_q <= h0_q;
          end
        end
        ST_EDIT_M1: begin
          if (btn_cancel) begin
            state_q    <= ST_IDLE;
            edit_pos_q <= 2'd0;
            busy_q     <= 1'b0;
          end else if (btn_ok) begin
            state_q    <= ST_EDIT_M0;
            edit_pos_q <= 2'd3;
          end else if (adj_s) begin
            m1_q <= m1_step_s;
          end else begin
            m1_q <= m1_q;
          end
        end
        ST_EDIT_M0: begin
          if (btn_cancel) begin
            state_q    <= ST_IDLE;
            edit_pos_q <= 2'd0;
            busy_q     <= 1'b0;
          end else if (btn_ok) begin
            state_q    <= ST_LOAD;
            edit_pos_q <= 2'd0;
            hold_q     <= HOLD_INIT;
            ld_time_q  <= (target_q == TGT_TIME);
            ld_alarm_q <= (target_q == TGT_ALARM);
          end else if (adj_s) begin
            m0_q <= m0_step_s;
          end else begin
            m0_q <= m0_q;
          end
        end
        ST_LOAD: begin
          // Strobe spans the edge that entered LOAD plus LD_HOLD-1 more edges.
          if (hold_q > HOLD_ONE) begin
            hold_q <= hold_q - HOLD_ONE;
          end else begin
            hold_q     <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          hold_q     <= '0;
          ld_time_q  <= 1'b0;
          ld_alarm_q <= 1'b0;
          edit_pos_q <= 2'd0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  snooze_timer #(
    .LD_HOLD      (LD_HOLD),
    .SNOOZE_TICKS (SNOOZE_S * TICKS_PER_S)
  ) u_snooze_timer (
    .clk           (clk),
    .reset         (reset),
    .btn_snooze_i  (btn_snooze),
    .btn_stop_i    (btn_stop),
    .alarm_in_i    (alarm_in),
    .stop_al_o     (STOP_al),
    .snooze_ring_o (snooze_ring_s)
  );

  assign H_in1    = h1_q;
  assign H_in0    = h0_q;
  assign M_in1    = m1_q;
  assign M_in0    = m0_q;
  assign LD_time  = ld_time_q;
  assign LD_alarm = ld_alarm_q;
  assign edit_pos = edit_pos_q;
  assign busy     = busy_q;
  assign ring     = alarm_in | snooze_ring_s;

endmodule
